// File: rtl/param_pkg.sv
// Shared pixel/lane parameters and types for the Bayer packing path.
package param_pkg;

  localparam int BITS  = 12;
  localparam int LANES = 8;
  localparam int CNT_W = $clog2(LANES);

  // Lane 0 sits in the least significant slot and holds the earliest pixel.
  typedef logic [LANES-1:0][BITS-1:0] lane_vec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LINE = 1'b1
  } pk_state_t;

endpackage

// File: rtl/pkr_sync_dly.sv
// Fixed-depth shift register for a 1-bit level signal (frame/line syncs).
module pkr_sync_dly #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sr;

  // Shift the level in one stage per clock; reset empties the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else begin
      r_sr <= {r_sr[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/bayer_pix_packer.sv
// Packs a 1-pixel-per-clock Bayer stream into 8-lane words and regenerates
// delayed frame/line syncs so every word lands inside its output line.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | outside a line; i_phsync high here is a line start
// ST_LINE | inside a line; i_phsync low here is a line end (flush)
module bayer_pix_packer
  import param_pkg::*;
#(
  parameter int SYNC_DLY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_data_en,
  input  logic            i_pvsync,
  input  logic            i_phsync,
  input  logic [BITS-1:0] i_data,
  output logic            o_data_en,
  output logic            o_pvsync,
  output logic            o_phsync,
  output logic [BITS-1:0] o_data_0,
  output logic [BITS-1:0] o_data_1,
  output logic [BITS-1:0] o_data_2,
  output logic [BITS-1:0] o_data_3,
  output logic [BITS-1:0] o_data_4,
  output logic [BITS-1:0] o_data_5,
  output logic [BITS-1:0] o_data_6,
  output logic [BITS-1:0] o_data_7,
  output logic            o_pad,
  output logic            o_stat_pad,
  output logic            o_stat_stray
);

  pk_state_t        r_state;
  pk_state_t        w_state_nxt;
  logic             r_pv_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_eff;
  lane_vec_t        r_cap;
  lane_vec_t        w_cap_nxt;
  lane_vec_t        w_flush_vec;
  lane_vec_t        r_out;
  logic [BITS-1:0]  w_last;
  logic             r_data_en;
  logic             r_pad;
  logic             r_stat_pad;
  logic             r_stat_stray;
  logic             w_rise;
  logic             w_fall;
  logic             w_accept;
  logic             w_stray;
  logic             w_full;
  logic             w_flush;
  logic             w_pv_rise;

  // Line-state register; also remembers previous i_pvsync for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pv_prev <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pv_prev <= i_pvsync;
    end
  end

  // Next-state logic; line start/end strobes fall out of the transitions.
  always_comb begin
    w_state_nxt = r_state;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_phsync) begin
          w_state_nxt = ST_LINE;
          w_rise      = 1'b1;
        end
      end
      ST_LINE: begin
        if (!i_phsync) begin
          w_state_nxt = ST_IDLE;
          w_fall      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Accept/stray decode, capture update and padded-word construction.
  always_comb begin
    w_accept  = i_data_en & i_phsync;
    w_stray   = i_data_en & ~i_phsync;
    // A pixel on the line-start cycle itself must land in lane 0.
    w_cnt_eff = w_rise ? '0 : r_cnt;
    w_full    = w_accept && (w_cnt_eff == CNT_W'(LANES - 1));
    w_flush   = w_fall && (r_cnt != '0);
    w_pv_rise = i_pvsync & ~r_pv_prev;

    w_cap_nxt = r_cap;
    if (w_accept) begin
      w_cap_nxt[w_cnt_eff] = i_data;
    end

    // Only meaningful when r_cnt != 0, which is all w_flush ever uses.
    w_last = r_cap[r_cnt - CNT_W'(1)];
    for (int i = 0; i < LANES; i++) begin
      w_flush_vec[i] = (CNT_W'(i) < r_cnt) ? r_cap[i] : w_last;
    end
  end

  // Lane counter and capture registers (first stage of the double buffer).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_cap <= '0;
    end else begin
      if (w_accept) begin
        r_cap <= w_cap_nxt;
        r_cnt <= w_cnt_eff + CNT_W'(1);
      end else if (w_fall || w_rise) begin
        r_cnt <= '0;
      end
    end
  end

  // Output word register; lanes and o_pad hold between words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_en <= 1'b0;
      r_pad     <= 1'b0;
      r_out     <= '0;
    end else begin
      r_data_en <= w_full | w_flush;
      if (w_full) begin
        r_out <= w_cap_nxt;
        r_pad <= 1'b0;
      end else if (w_flush) begin
        r_out <= w_flush_vec;
        r_pad <= 1'b1;
      end
    end
  end

  // Sticky status flags: cleared at frame start, a coincident set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_pad   <= 1'b0;
      r_stat_stray <= 1'b0;
    end else begin
      if (w_flush) begin
        r_stat_pad <= 1'b1;
      end else if (w_pv_rise) begin
        r_stat_pad <= 1'b0;
      end
      if (w_stray) begin
        r_stat_stray <= 1'b1;
      end else if (w_pv_rise) begin
        r_stat_stray <= 1'b0;
      end
    end
  end

  pkr_sync_dly #(.DEPTH(SYNC_DLY)) u_pv_dly (
    .clk (clk),
    .rst (rst),
    .i_d (i_pvsync),
    .o_q (o_pvsync)
  );

  pkr_sync_dly #(.DEPTH(SYNC_DLY)) u_ph_dly (
    .clk (clk),
    .rst (rst),
    .i_d (i_phsync),
    .o_q (o_phsync)
  );

  assign o_data_en    = r_data_en;
  assign o_pad        = r_pad;
  assign o_stat_pad   = r_stat_pad;
  assign o_stat_stray = r_stat_stray;
  assign o_data_0     = r_out[0];
  assign o_data_1     = r_out[1];
  assign o_data_2     = r_out[2];
  assign o_data_3     = r_out[3];
  assign o_data_4     = r_out[4];
  assign o_data_5     = r_out[5];
  assign o_data_6     = r_out[6];
  assign o_data_7     = r_out[7];

endmodule

// File: tb/tb_bayer_pix_packer.sv
// Bench for bayer_pix_packer: drives lines of pixels, predicts the packed
// words from the pixel list alone and compares content, padding and timing.
module tb_bayer_pix_packer;
  import param_pkg::*;

  logic            clk;
  logic            rst;
  logic            i_data_en;
  logic            i_pvsync;
  logic            i_phsync;
  logic [BITS-1:0] i_data;
  logic            o_data_en;
  logic            o_pvsync;
  logic            o_phsync;
  logic [BITS-1:0] o_data_0, o_data_1, o_data_2, o_data_3;
  logic [BITS-1:0] o_data_4, o_data_5, o_data_6, o_data_7;
  logic            o_pad;
  logic            o_stat_pad;
  logic            o_stat_stray;

  typedef struct {
    lane_vec_t lanes;
    logic      pad;
    int        cyc;
    logic      ph;
  } word_t;

  word_t got_q[$];
  word_t exp_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    exp_pad = 0;
  bit    exp_stray = 0;

  bayer_pix_packer #(.SYNC_DLY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_data_en    (i_data_en),
    .i_pvsync     (i_pvsync),
    .i_phsync     (i_phsync),
    .i_data       (i_data),
    .o_data_en    (o_data_en),
    .o_pvsync     (o_pvsync),
    .o_phsync     (o_phsync),
    .o_data_0     (o_data_0),
    .o_data_1     (o_data_1),
    .o_data_2     (o_data_2),
    .o_data_3     (o_data_3),
    .o_data_4     (o_data_4),
    .o_data_5     (o_data_5),
    .o_data_6     (o_data_6),
    .o_data_7     (o_data_7),
    .o_pad        (o_pad),
    .o_stat_pad   (o_stat_pad),
    .o_stat_stray (o_stat_stray)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every emitted word with the edge number that produced it.
  always @(negedge clk) begin : mon
    word_t w;
    if (o_data_en === 1'b1) begin
      w.lanes = {o_data_7, o_data_6, o_data_5, o_data_4,
                 o_data_3, o_data_2, o_data_1, o_data_0};
      w.pad   = o_pad;
      w.cyc   = cyc;
      w.ph    = o_phsync;
      got_q.push_back(w);
    end
  end

  // Drive one cycle of inputs; e is the clock edge that samples them.
  task automatic step(input logic en, input logic ph, input logic pv,
                      input logic [BITS-1:0] d, output int e);
    @(negedge clk);
    i_data_en = en;
    i_phsync  = ph;
    i_pvsync  = pv;
    i_data    = d;
    e = cyc + 1;
  endtask

  // One line: optional new frame, optional stray pixels before the line and
  // on its falling cycle, then predicted words are compared with observed.
  task automatic do_line(input string name, input int n, input int base,
                         input int gapmode, input bit new_frame, input bit strays);
    logic [BITS-1:0] pix[$];
    int              pe[$];
    int              e, fe, g, nw, idx, m;
    logic [BITS-1:0] v;
    word_t           w;
    if (new_frame) begin
      step(1'b0, 1'b0, 1'b0, '0, e);
      step(1'b0, 1'b0, 1'b1, '0, e);
      exp_pad   = 0;
      exp_stray = 0;
    end
    step(1'b0, 1'b0, 1'b1, '0, e);
    if (strays) step(1'b1, 1'b0, 1'b1, 12'hABC, e);
    for (int i = 0; i < n; i++) begin
      v = (base < 0) ? 12'($urandom) : 12'(base + i);
      if (i > 0) begin
        g = (gapmode == 1) ? 1 : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (g) step(1'b0, 1'b1, 1'b1, 12'($urandom), e);
      end
      step(1'b1, 1'b1, 1'b1, v, e);
      pix.push_back(v);
      pe.push_back(e);
    end
    step(strays, 1'b0, 1'b1, 12'hABC, fe);
    repeat (4) step(1'b0, 1'b0, 1'b1, '0, e);

    if (n % 8 != 0) exp_pad = 1;
    if (strays) exp_stray = 1;
    nw = (n + 7) / 8;
    for (int wi = 0; wi < nw; wi++) begin
      for (int l = 0; l < LANES; l++) begin
        idx = wi * 8 + l;
        w.lanes[l] = (idx < n) ? pix[idx] : pix[n-1];
      end
      w.pad = (wi * 8 + 8 > n);
      w.cyc = w.pad ? fe : pe[wi*8+7];
      w.ph  = 1'b1;
      exp_q.push_back(w);
    end

    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s word_count got %0d exp %0d", name, got_q.size(), exp_q.size());
    end
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (got_q[i].lanes !== exp_q[i].lanes) begin
        errors++;
        $display("FAIL %s word%0d lanes got %h exp %h", name, i, got_q[i].lanes, exp_q[i].lanes);
      end
      checks++;
      if (got_q[i].pad !== exp_q[i].pad) begin
        errors++;
        $display("FAIL %s word%0d pad got %b exp %b", name, i, got_q[i].pad, exp_q[i].pad);
      end
      checks++;
      if (got_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL %s word%0d edge got %0d exp %0d", name, i, got_q[i].cyc, exp_q[i].cyc);
      end
      checks++;
      if (got_q[i].ph !== 1'b1) begin
        errors++;
        $display("FAIL %s word%0d outside o_phsync window got %b exp 1", name, i, got_q[i].ph);
      end
    end
    checks++;
    if (o_stat_pad !== exp_pad) begin
      errors++;
      $display("FAIL %s stat_pad got %b exp %b", name, o_stat_pad, exp_pad);
    end
    checks++;
    if (o_stat_stray !== exp_stray) begin
      errors++;
      $display("FAIL %s stat_stray got %b exp %b", name, o_stat_stray, exp_stray);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset;
    logic [BITS*8+6:0] all;
    rst       = 1'b1;
    i_data_en = 1'b0;
    i_pvsync  = 1'b0;
    i_phsync  = 1'b0;
    i_data    = '0;
    repeat (3) @(negedge clk);
    all = {o_data_en, o_pvsync, o_phsync, o_pad, o_stat_pad, o_stat_stray, 1'b0,
           o_data_7, o_data_6, o_data_5, o_data_4, o_data_3, o_data_2, o_data_1, o_data_0};
    checks++;
    if (all !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", all);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray;
    int e;
    do_line("stray_line", 3, 7, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, e);
    step(1'b0, 1'b0, 1'b1, '0, e);
    step(1'b0, 1'b0, 1'b1, '0, e);
    checks++;
    if (o_stat_stray !== 1'b0) begin
      errors++;
      $display("FAIL stray_clear got %b exp 0", o_stat_stray);
    end
    checks++;
    if (o_stat_pad !== 1'b0) begin
      errors++;
      $display("FAIL pad_clear got %b exp 0", o_stat_pad);
    end
    // Stray pixel on the very cycle of a frame-start: set must win.
    step(1'b0, 1'b0, 1'b0, '0, e);
    step(1'b1, 1'b0, 1'b1, 12'hABC, e);
    step(1'b0, 1'b0, 1'b1, '0, e);
    checks++;
    if (o_stat_stray !== 1'b1) begin
      errors++;
      $display("FAIL stray_set_wins got %b exp 1", o_stat_stray);
    end
  endtask

  task automatic test_reset_midline;
    int e;
    logic [BITS*8+6:0] all;
    step(1'b0, 1'b0, 1'b0, '0, e);
    step(1'b0, 1'b0, 1'b1, '0, e);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 12'(50 + i), e);
    @(negedge clk);
    rst       = 1'b1;
    i_data_en = 1'b0;
    i_phsync  = 1'b0;
    got_q.delete();
    @(negedge clk);
    all = {o_data_en, o_pvsync, o_phsync, o_pad, o_stat_pad, o_stat_stray, 1'b0,
           o_data_7, o_data_6, o_data_5, o_data_4, o_data_3, o_data_2, o_data_1, o_data_0};
    checks++;
    if (all !== '0) begin
      errors++;
      $display("FAIL midline_reset_outputs got %h exp 0", all);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_pvsync, o_phsync} !== 2'b00) begin
      errors++;
      $display("FAIL sync_after_reset_1 got %b exp 00", {o_pvsync, o_phsync});
    end
    @(negedge clk);
    checks++;
    if ({o_pvsync, o_phsync} !== 2'b10) begin
      errors++;
      $display("FAIL sync_after_reset_2 got %b exp 10", {o_pvsync, o_phsync});
    end
    exp_pad   = 0;
    exp_stray = 0;
    do_line("post_reset_line", 8, 20, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 10; k++) begin
      do_line("random_line", int'($urandom_range(1, 30)), -1, 2,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    do_line("full16", 16, 0, 0, 1'b1, 1'b0);
    do_line("pad11", 11, 100, 0, 1'b1, 1'b0);
    do_line("gapped16", 16, 0, 1, 1'b1, 1'b0);
    test_stray();
    test_reset_midline();
    do_line("exact8", 8, 200, 0, 1'b1, 1'b0);
    do_line("single1", 1, 300, 0, 1'b1, 1'b0);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
